instr_mem_loader: RTL and testbench

Sequences writes into the writable instruction memory from a byte-serial host stream (e.g. a UART receiver), so programs load at run time instead of from a memory init file. It decodes a 2-byte word-count header, assembles little-endian bytes into 32-bit words, and issues one write per word at incrementing addresses from 0. It holds the CPU in stall for the whole load and reports done or error.

---
 rtl/instr_mem_pkg.sv | 25 ++
 rtl/instr_mem_loader_word_assembler.sv | 45 ++++
 rtl/instr_mem_loader.sv | 182 ++++++++++++++++++
 tb/tb_instr_mem_loader.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_pkg.sv
// -----------------------------------------------------------------------------
// instr_mem_pkg
// Shared types and constants for the instruction-memory loader.
//   loader_state_t : loader FSM states
//   HDR_BYTES      : bytes in the word-count header (little-endian)
//   BYTES_PER_WORD : bytes packed into each 32-bit instruction word
//   word_count_t   : unsigned word count carried by the header
// -----------------------------------------------------------------------------
package instr_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_LO,
    HDR_HI,
    DATA,
    WRITE,
    DONE
  } loader_state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  typedef logic [HDR_BYTES*8-1:0] word_count_t;

endpackage

// File: rtl/instr_mem_loader_word_assembler.sv
// -----------------------------------------------------------------------------
// word_assembler
// Packs a byte stream little-endian into 32-bit words: the first byte of a
// word lands in bits [7:0], the last in bits [31:24].
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   clear        : synchronous clear of byte index and partial word
//   byte_strobe  : a byte is being accepted this cycle
//   byte_in      : the byte being accepted
//   word         : packed word register (complete after the 4th strobe)
//   word_full    : high in the cycle the last byte of a word is strobed
// -----------------------------------------------------------------------------
module word_assembler
  import instr_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_strobe,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0] byte_idx;

  // Shifting in from the top means that after four bytes the first byte has
  // walked down to [7:0]. The index wraps naturally back to 0 for the next
  // word, so no explicit clear is needed between words of one load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx <= '0;
      word     <= '0;
    end else if (clear) begin
      byte_idx <= '0;
      word     <= '0;
    end else if (byte_strobe) begin
      byte_idx <= byte_idx + 2'd1;
      word     <= {byte_in, word[31:8]};
    end
  end

  assign word_full = byte_strobe && (byte_idx == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instr_mem_loader.sv
// -----------------------------------------------------------------------------
// instr_mem_loader
// Loads a program into the writable instruction memory from a byte-serial
// host stream. Stream format: 16-bit little-endian word count N, then N
// little-endian 32-bit words written to addresses 0..N-1. The CPU is stalled
// for the whole load; completion pulses load_done, a rejected header
// (N > memory_size) or an abort pulses load_err.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   load_start          : begin a load (only honoured in IDLE)
//   load_abort          : abandon the load in progress (not in IDLE/DONE)
//   in_valid, in_data   : byte stream, accepted when in_valid && in_ready
//   in_ready            : loader can accept a byte this cycle
//   mem_we, mem_waddr,
//   mem_wdata           : instruction memory write port (address/data hold
//                         their last values while mem_we is low)
//   cpu_stall           : registered, high whenever the loader is not IDLE
//   load_done, load_err : one-cycle status pulses
// -----------------------------------------------------------------------------
module instr_mem_loader
  import instr_mem_pkg::*;
#(
  parameter int memory_size      = 64,
  parameter int memory_addr_size = 6
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load_start,
  input  logic                        load_abort,
  input  logic                        in_valid,
  input  logic [7:0]                  in_data,
  output logic                        in_ready,
  output logic                        mem_we,
  output logic [memory_addr_size-1:0] mem_waddr,
  output logic [31:0]                 mem_wdata,
  output logic                        cpu_stall,
  output logic                        load_done,
  output logic                        load_err
);

  loader_state_t state, next_state;

  logic [(HDR_BYTES-1)*8-1:0]  count_lo;
  word_count_t                 hdr_count;
  word_count_t                 remaining;
  logic [memory_addr_size-1:0] addr;
  logic [memory_addr_size-1:0] waddr_hold;
  logic [31:0]                 wdata_hold;

  logic        abort_ok;
  logic        byte_fire;
  logic        err_event;
  logic        asm_clear;
  logic        asm_strobe;
  logic        asm_full;
  logic [31:0] asm_word;

  // An abort only counts while a load is actually being received or written;
  // in DONE the completion already happened and wins.
  assign abort_ok = load_abort && (state inside {HDR_LO, HDR_HI, DATA, WRITE});

  // in_ready and mem_we are kept out of the next-state block so the
  // handshake -> word_full -> next_state path is a plain forward path.
  assign in_ready  = (state inside {HDR_LO, HDR_HI, DATA}) && !abort_ok;
  assign mem_we    = (state == WRITE) && !abort_ok;
  assign byte_fire = in_valid && in_ready;
  assign load_done = (state == DONE);

  // The full 16-bit count is only valid in the cycle the high byte is taken.
  assign hdr_count = {in_data, count_lo};

  assign asm_strobe = byte_fire && (state == DATA);
  assign asm_clear  = abort_ok || ((state == IDLE) && load_start);

  word_assembler u_word_assembler (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (asm_clear),
    .byte_strobe (asm_strobe),
    .byte_in     (in_data),
    .word        (asm_word),
    .word_full   (asm_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic. The header is classified in the same cycle its high
  // byte is accepted; an abort overrides whatever the state wanted to do.
  always_comb begin
    next_state = state;
    err_event  = 1'b0;
    case (state)
      IDLE: begin
        if (load_start) next_state = HDR_LO;
      end
      HDR_LO: begin
        if (byte_fire) next_state = HDR_HI;
      end
      HDR_HI: begin
        if (byte_fire) begin
          if (hdr_count == '0) begin
            next_state = DONE;
          end else if (hdr_count > word_count_t'(memory_size)) begin
            next_state = IDLE;
            err_event  = 1'b1;
          end else begin
            next_state = DATA;
          end
        end
      end
      DATA: begin
        if (asm_full) next_state = WRITE;
      end
      WRITE: begin
        next_state = (remaining > word_count_t'(1)) ? DATA : DONE;
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
    if (abort_ok) begin
      next_state = IDLE;
      err_event  = 1'b1;
    end
  end

  // Header capture, words-remaining and write address. The address is not
  // bumped after the final word, so it stays inside the memory range even
  // for a full-size load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_lo  <= '0;
      remaining <= '0;
      addr      <= '0;
    end else begin
      if (byte_fire && (state == HDR_LO)) begin
        count_lo <= in_data;
      end
      if (byte_fire && (state == HDR_HI)) begin
        remaining <= hdr_count;
        addr      <= '0;
      end
      if (mem_we) begin
        remaining <= remaining - word_count_t'(1);
        if (remaining > word_count_t'(1)) addr <= addr + 1'b1;
      end
    end
  end

  // Last-written address/data, so the write port holds steady between writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waddr_hold <= '0;
      wdata_hold <= '0;
    end else if (mem_we) begin
      waddr_hold <= addr;
      wdata_hold <= asm_word;
    end
  end

  assign mem_waddr = mem_we ? addr     : waddr_hold;
  assign mem_wdata = mem_we ? asm_word : wdata_hold;

  // Stall follows the state being entered, so it drops in the same cycle the
  // FSM is back in IDLE. The error pulse appears the cycle after its cause.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_stall <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      cpu_stall <= (next_state != IDLE);
      load_err  <= err_event;
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_mem_loader
// Self-checking bench for instr_mem_loader: hand-written cycle sequences for
// the timing corner cases, a table of header counts with expected outcomes,
// and randomized loads with random stream gaps against a stream-level model.
// -----------------------------------------------------------------------------
module tb_instr_mem_loader;
  import instr_mem_pkg::*;

  localparam int MEM_SIZE = 64;
  localparam int ADDR_W   = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              load_start = 1'b0;
  logic              load_abort = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic              cpu_stall;
  logic              load_done;
  logic              load_err;

  always #5 clk = ~clk;

  instr_mem_loader #(
    .memory_size      (MEM_SIZE),
    .memory_addr_size (ADDR_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .load_abort (load_abort),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .cpu_stall  (cpu_stall),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [31:0]       wr_data_q[$];
  logic [31:0]       tb_mem [MEM_SIZE];

  typedef struct {
    logic [15:0] count;
    bit          exp_err;
    int          exp_writes;
  } vec_t;

  vec_t vectors [8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Write/pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) begin
        wr_addr_q.push_back(mem_waddr);
        wr_data_q.push_back(mem_wdata);
        tb_mem[mem_waddr] = mem_wdata;
        checkOutput("ready_during_write", {31'd0, in_ready}, 32'd0);
      end
      if (load_done) done_cnt++;
      if (load_err)  err_cnt++;
    end
  end

  // Drive one cycle's inputs and advance to the sampling point (falling edge).
  task automatic applyStimulus(input logic s, input logic a, input logic v, input logic [7:0] d);
    load_start = s;
    load_abort = a;
    in_valid   = v;
    in_data    = d;
    @(negedge clk);
  endtask

  task automatic finishCycle();
    @(posedge clk);
    #1;
    load_start = 1'b0;
    load_abort = 1'b0;
    in_valid   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      finishCycle();
    end
  endtask

  task automatic sendByte(input logic [7:0] b, input int gap, input int limit, output bit ok);
    int waited;
    ok = 1'b0;
    waited = 0;
    idle(gap);
    while (!ok && waited < limit) begin
      applyStimulus(1'b0, 1'b0, 1'b1, b);
      ok = in_ready;
      finishCycle();
      waited++;
    end
  endtask

  task automatic sendBytes(input logic [7:0] s[$], input string tag);
    bit ok;
    int acc;
    acc = 0;
    foreach (s[i]) begin
      sendByte(s[i], 0, 3, ok);
      if (ok) acc++;
    end
    checkOutput({tag, "_accept"}, 32'(acc), 32'(s.size()));
  endtask

  task automatic startLoad();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    finishCycle();
  endtask

  // Stream-level reference: header gives N; N==0 completes, N>MEM_SIZE is
  // rejected, otherwise word w is bytes 2+4w..5+4w weighted little-endian.
  task automatic modelLoad(input logic [7:0] stream_in[$], output bit exp_err,
                           output bit exp_done, output logic [31:0] exp_words[$]);
    int n;
    n = int'(stream_in[0]) + 256 * int'(stream_in[1]);
    exp_words = {};
    exp_err   = (n > MEM_SIZE);
    exp_done  = !exp_err;
    if (!exp_err) begin
      for (int w = 0; w < n; w++) begin
        longint v;
        v = 0;
        for (int k = 0; k < BYTES_PER_WORD; k++)
          v += longint'(stream_in[HDR_BYTES + 4*w + k]) * (longint'(1) << (8*k));
        exp_words.push_back(32'(v));
      end
    end
  endtask

  task automatic runProgram(input logic [15:0] count, input int max_gap, input bit use_tbl,
                            input bit tbl_err, input int tbl_writes);
    logic [7:0]  stream[$];
    logic [31:0] mw[$];
    bit          me, md, ok;
    int          d0, e0, acc, nw;
    stream = {};
    stream.push_back(count[7:0]);
    stream.push_back(count[15:8]);
    if (count >= 16'd1 && int'(count) <= MEM_SIZE)
      for (int i = 0; i < 4*int'(count); i++) stream.push_back(8'($urandom_range(0, 255)));
    modelLoad(stream, me, md, mw);
    wr_addr_q = {};
    wr_data_q = {};
    d0 = done_cnt;
    e0 = err_cnt;
    acc = 0;
    startLoad();
    foreach (stream[i]) begin
      sendByte(stream[i], $urandom_range(0, max_gap), 20, ok);
      if (ok) acc++;
    end
    checkOutput("stream_accept", 32'(acc), 32'(stream.size()));
    if (me) begin
      sendByte(8'hA5, 0, 5, ok);
      checkOutput("reject_after_err", {31'd0, ok}, 32'd0);
    end
    idle(3);
    checkOutput("err_pulses", 32'(err_cnt - e0), {31'd0, me});
    checkOutput("done_pulses", 32'(done_cnt - d0), {31'd0, md});
    checkOutput("write_count", 32'(wr_addr_q.size()), 32'(mw.size()));
    if (use_tbl) begin
      checkOutput("tbl_err", 32'(err_cnt - e0), {31'd0, tbl_err});
      checkOutput("tbl_writes", 32'(wr_addr_q.size()), 32'(tbl_writes));
    end
    nw = (wr_addr_q.size() < mw.size()) ? wr_addr_q.size() : mw.size();
    for (int i = 0; i < nw; i++) begin
      checkOutput("waddr", 32'(wr_addr_q[i]), 32'(i));
      checkOutput("wdata", wr_data_q[i], mw[i]);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("stall_after", {31'd0, cpu_stall}, 32'd0);
    finishCycle();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] q[$];
    int d0, e0, nwr;

    vectors[0] = '{16'd1,    1'b0, 1};
    vectors[1] = '{16'd3,    1'b0, 3};
    vectors[2] = '{16'd63,   1'b0, 63};
    vectors[3] = '{16'd64,   1'b0, 64};
    vectors[4] = '{16'd65,   1'b1, 0};
    vectors[5] = '{16'h0041, 1'b1, 0};
    vectors[6] = '{16'hFFFF, 1'b1, 0};
    vectors[7] = '{16'd0,    1'b0, 0};

    // Reset state
    in_valid = 1'b1;
    #12;
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("rst_mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("rst_waddr", 32'(mem_waddr), 32'd0);
    checkOutput("rst_wdata", mem_wdata, 32'd0);
    checkOutput("rst_stall", {31'd0, cpu_stall}, 32'd0);
    checkOutput("rst_done", {31'd0, load_done}, 32'd0);
    checkOutput("rst_err", {31'd0, load_err}, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(1);

    // Nominal two-word load with exact write timing
    d0 = done_cnt;
    startLoad();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("nom_stall_hdr", {31'd0, cpu_stall}, 32'd1);
    checkOutput("nom_ready_hdr", {31'd0, in_ready}, 32'd1);
    finishCycle();
    q = {8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00};
    sendBytes(q, "nom_w0");
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("nom_we0", {31'd0, mem_we}, 32'd1);
    checkOutput("nom_addr0", 32'(mem_waddr), 32'd0);
    checkOutput("nom_data0", mem_wdata, 32'h00100513);
    checkOutput("nom_ready_write", {31'd0, in_ready}, 32'd0);
    finishCycle();
    q = {8'h93, 8'h05, 8'h20, 8'h00};
    sendBytes(q, "nom_w1");
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("nom_we1", {31'd0, mem_we}, 32'd1);
    checkOutput("nom_addr1", 32'(mem_waddr), 32'd1);
    checkOutput("nom_data1", mem_wdata, 32'h00200593);
    finishCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("nom_done", {31'd0, load_done}, 32'd1);
    checkOutput("nom_stall_done", {31'd0, cpu_stall}, 32'd1);
    finishCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("nom_done_off", {31'd0, load_done}, 32'd0);
    checkOutput("nom_stall_idle", {31'd0, cpu_stall}, 32'd0);
    checkOutput("nom_hold_addr", 32'(mem_waddr), 32'd1);
    checkOutput("nom_hold_data", mem_wdata, 32'h00200593);
    finishCycle();
    checkOutput("nom_done_count", 32'(done_cnt - d0), 32'd1);

    // Zero count completes one cycle after the header
    nwr = wr_addr_q.size();
    startLoad();
    q = {8'h00, 8'h00};
    sendBytes(q, "zero_hdr");
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("zero_done", {31'd0, load_done}, 32'd1);
    finishCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("zero_stall", {31'd0, cpu_stall}, 32'd0);
    checkOutput("zero_writes", 32'(wr_addr_q.size()), 32'(nwr));
    finishCycle();

    // Oversize header: error pulse next cycle, no further bytes taken
    startLoad();
    q = {8'h41, 8'h00};
    sendBytes(q, "over_hdr");
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h13);
    checkOutput("over_err", {31'd0, load_err}, 32'd1);
    checkOutput("over_stall", {31'd0, cpu_stall}, 32'd0);
    checkOutput("over_ready", {31'd0, in_ready}, 32'd0);
    finishCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("over_err_off", {31'd0, load_err}, 32'd0);
    finishCycle();

    // Abort while in DONE is ignored
    startLoad();
    q = {8'h00, 8'h00};
    sendBytes(q, "dabort_hdr");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("dabort_done", {31'd0, load_done}, 32'd1);
    finishCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("dabort_no_err", {31'd0, load_err}, 32'd0);
    finishCycle();

    // Abort mid-word: word 0 kept, no write to addr 1, then a fresh load
    wr_addr_q = {};
    wr_data_q = {};
    startLoad();
    q = {8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    sendBytes(q, "abort_w0");
    idle(1);
    q = {8'h55, 8'h66};
    sendBytes(q, "abort_part");
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h77);
    checkOutput("abort_ready", {31'd0, in_ready}, 32'd0);
    finishCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("abort_err", {31'd0, load_err}, 32'd1);
    checkOutput("abort_stall", {31'd0, cpu_stall}, 32'd0);
    finishCycle();
    idle(2);
    checkOutput("abort_writes", 32'(wr_addr_q.size()), 32'd1);
    checkOutput("abort_mem0", tb_mem[0], 32'h44332211);
    startLoad();
    q = {8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    sendBytes(q, "fresh");
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("fresh_we", {31'd0, mem_we}, 32'd1);
    checkOutput("fresh_addr", 32'(mem_waddr), 32'd0);
    checkOutput("fresh_data", mem_wdata, 32'hDDCCBBAA);
    finishCycle();
    idle(2);

    // Abort in the write cycle suppresses the write
    e0 = err_cnt;
    startLoad();
    q = {8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    sendBytes(q, "wabort");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("wabort_we", {31'd0, mem_we}, 32'd0);
    checkOutput("wabort_hold", mem_wdata, 32'hDDCCBBAA);
    finishCycle();
    idle(2);
    checkOutput("wabort_err", 32'(err_cnt - e0), 32'd1);

    // load_start during DATA is ignored
    wr_addr_q = {};
    wr_data_q = {};
    startLoad();
    q = {8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    sendBytes(q, "misuse_w0");
    idle(1);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    finishCycle();
    q = {8'h78, 8'h56, 8'h34, 8'h12};
    sendBytes(q, "misuse_w1");
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("misuse_we", {31'd0, mem_we}, 32'd1);
    checkOutput("misuse_addr", 32'(mem_waddr), 32'd1);
    checkOutput("misuse_data", mem_wdata, 32'h12345678);
    finishCycle();
    idle(2);

    // Reset asserted mid-DATA
    startLoad();
    q = {8'h01, 8'h00, 8'h01, 8'h02};
    sendBytes(q, "rst_mid");
    d0 = done_cnt;
    e0 = err_cnt;
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rstmid_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("rstmid_stall", {31'd0, cpu_stall}, 32'd0);
    checkOutput("rstmid_we", {31'd0, mem_we}, 32'd0);
    checkOutput("rstmid_waddr", 32'(mem_waddr), 32'd0);
    checkOutput("rstmid_wdata", mem_wdata, 32'd0);
    checkOutput("rstmid_done", {31'd0, load_done}, 32'd0);
    checkOutput("rstmid_err", {31'd0, load_err}, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(3);
    checkOutput("rstmid_no_done", 32'(done_cnt - d0), 32'd0);
    checkOutput("rstmid_no_err", 32'(err_cnt - e0), 32'd0);

    // Table of header counts with expected outcome
    foreach (vectors[i])
      runProgram(vectors[i].count, 2, 1'b1, vectors[i].exp_err, vectors[i].exp_writes);

    // Randomized loads with random stream gaps
    for (int r = 0; r < 6; r++)
      runProgram(16'($urandom_range(1, 16)), 3, 1'b0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
